mem_responder: RTL
==================

Name: mem_responder

Overview:
- Memory-side responder for the multi-cycle CPU's memory requests (instruction fetch, load, store).
- Services one request at a time with a programmable number of wait cycles.
- Returns a one-cycle response pulse with read data and an error flag.
- Lets the CPU control path run against slow or variable-latency memory instead of single-cycle memory.

Parameters:
- ADDR_W, 32, byte-address width of req_addr.
- DATA_W, 32, data word width.
- DEPTH_LOG2, 8, log2 of the number of words in the internal array (256 words).
- LATENCY, 2, wait cycles between accept and response; legal range 0..15.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  byte address; must be word aligned.
- req_wdata  in  DATA_W  write data.
- req_ready  out  1  responder can accept a request this cycle.
- resp_valid  out  1  one-cycle response pulse.
- resp_rdata  out  DATA_W  read data; 0 for writes and errors.
- resp_err  out  1  request was misaligned or out of range; qualified by resp_valid.
- busy  out  1  request outstanding (WAIT or RESP state).
- state  out  2  current FSM state, for debug.

Behaviour:
- FSM states: IDLE=2'b00, WAIT=2'b01, RESP=2'b10. 2'b11 is illegal and returns to IDLE on the next edge.
- Reset (rst low): asynchronous entry to IDLE. resp_valid=0, resp_rdata=0, resp_err=0, busy=0, wait counter=0, captured request cleared. req_ready=1 while in IDLE.
- Array contents are not reset.
- req_ready is combinational: 1 in IDLE and RESP, 0 in WAIT.
- Accept: req_valid & req_ready at a rising edge. Capture req_we, req_addr and req_wdata, and evaluate the error condition.
  - LATENCY=0: next state RESP.
  - LATENCY>0: next state WAIT, counter loaded with LATENCY.
- WAIT: counter decrements each cycle. On the edge where the counter equals 1, move to RESP.
- Array access occurs on the edge that enters RESP:
  - Write: stores the captured wdata at word index addr[DEPTH_LOG2+1:2].
  - Read: registers the array word into resp_rdata.
- RESP lasts exactly one cycle, with resp_valid=1.
  - If a new request is accepted in RESP, the FSM goes to WAIT, or to RESP again when LATENCY=0.
  - Otherwise it goes to IDLE.
- Latency: a request accepted at edge t gives resp_valid high in the cycle after edge t+LATENCY. That is LATENCY+1 cycles from accept to response.
- Sustained throughput: one request per LATENCY+1 cycles.
- Error condition: addr[1:0]!=0, or any bit of addr[ADDR_W-1:DEPTH_LOG2+2] set. On error, no array write occurs, resp_rdata=0 and resp_err=1.
- Ordering: requests complete in acceptance order. A read accepted after a write to the same address returns the written data.
- req_valid while req_ready=0 is ignored. The requester must hold req_valid until the request is accepted.
- Input changes during WAIT have no effect, because the request was captured at accept.
- Reset mid-operation: an outstanding request is discarded and resp_valid is never asserted for it. A write is discarded if the edge entering RESP has not yet occurred.
- Outside RESP, resp_valid=0, resp_err=0, and resp_rdata holds its last value. Verify resp_rdata only when resp_valid=1.
- busy = (state != IDLE).

Decomposition:
- Shared package mem_pkg holds:
  - state encodings (IDLE, WAIT, RESP);
  - the counter width constant (4 bits);
  - the word-index slice helper constant (DEPTH_LOG2+2 offset).
- One sub-module, mem_array: synchronous single-port RAM with parameters DATA_W and DEPTH_LOG2, write enable, registered read, no reset.
- The FSM, counter, capture registers and error check live in mem_responder.

Test Plan:
- Reset release: rst low, then high → state=00, req_ready=1, busy=0, resp_valid=0.
- Write then read, LATENCY=2: write 0xDEADBEEF at address 0x10, accepted at edge t → resp_valid at cycle t+3 with resp_err=0. Then read 0x10 → resp_rdata=0xDEADBEEF and resp_valid exactly 3 cycles after accept.
- Back-to-back, LATENCY=0: hold req_valid for 4 reads of addresses 0x0, 0x4, 0x8 and 0xC, preloaded with 1, 2, 3 and 4 → resp_valid high on 4 consecutive cycles with rdata 1, 2, 3, 4; req_ready stays 1.
- Errors:
  - Read at 0x12 → resp_err=1, rdata=0.
  - Write at 0x400 (DEPTH_LOG2=8) → resp_err=1.
  - Follow-up read of 0x0 → unchanged prior value.
- Stall: LATENCY=3, toggle req_addr during WAIT → req_ready=0 for 3 cycles; response reflects the captured address; the changed inputs are not accepted.
- Reset mid-operation: LATENCY=5, write 0xAA at 0x20, assert rst at WAIT cycle 2 → no resp_valid; after release, read 0x20 returns its prior value (not 0xAA).

Source files
------------

// File: rtl/mem_pkg.sv
// Shared constants for the memory responder: FSM encodings, wait-counter width
// and the word-index slice offsets.
`timescale 1ns/1ps
package mem_pkg;

   localparam int unsigned STATE_W = 2;

   localparam logic [STATE_W-1:0] IDLE = 2'b00;
   localparam logic [STATE_W-1:0] WAIT = 2'b01;
   localparam logic [STATE_W-1:0] RESP = 2'b10;

   localparam int unsigned CNT_W = 4;

   // Byte-address bits below the word index.
   localparam int unsigned WORD_LSB = 2;

   // First address bit above the word index; any set bit there is out of range.
   function automatic int unsigned highLsb(input int unsigned depthLog2);
      return depthLog2 + WORD_LSB;
   endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bus between the CPU memory port and the responder.
`timescale 1ns/1ps
interface mem_responder_if
   import mem_pkg::*;
#(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
) ();

   logic               req_valid;
   logic               req_we;
   logic [ADDR_W-1:0]  req_addr;
   logic [DATA_W-1:0]  req_wdata;
   logic               req_ready;
   logic               resp_valid;
   logic [DATA_W-1:0]  resp_rdata;
   logic               resp_err;
   logic               busy;
   logic [STATE_W-1:0] state;

   modport master (
      output req_valid, req_we, req_addr, req_wdata,
      input  req_ready, resp_valid, resp_rdata, resp_err, busy, state
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata,
      output req_ready, resp_valid, resp_rdata, resp_err, busy, state
   );

endinterface

// File: rtl/mem_array.sv
// Single-port synchronous RAM with registered read; contents are never reset.
`timescale 1ns/1ps
module mem_array #(
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned DEPTH_LOG2 = 8
) (
   input  logic                  clk,
   input  logic                  en,
   input  logic                  we,
   input  logic [DEPTH_LOG2-1:0] addr,
   input  logic [DATA_W-1:0]     wdata,
   output logic [DATA_W-1:0]     rdata
);

   logic [DATA_W-1:0] mem [2**DEPTH_LOG2];

   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            mem[addr] <= wdata;
         end else begin
            rdata <= mem[addr];
         end
      end
   end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: accepts one request at a time, waits LATENCY cycles,
// then issues a one-cycle response carrying read data and an error flag.
`timescale 1ns/1ps
module mem_responder
   import mem_pkg::*;
#(
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned DEPTH_LOG2 = 8,
   parameter int unsigned LATENCY    = 2
) (
   input  logic          clk,
   input  logic          rst,
   mem_responder_if.slave bus
);

   localparam logic [CNT_W-1:0] LAT    = CNT_W'(LATENCY);
   localparam int unsigned      HI_LSB = highLsb(DEPTH_LOG2);

   logic [STATE_W-1:0]    stateQ, stateD;
   logic [CNT_W-1:0]      cntQ, cntD;
   logic                  capWe, capErr;
   logic [DEPTH_LOG2-1:0] capIdx;
   logic [DATA_W-1:0]     capWdata;
   logic                  respErrQ, zeroQ;

   logic                  accept, reqErr, enterResp;
   logic                  accWe, accErr;
   logic [DEPTH_LOG2-1:0] accIdx, reqIdx;
   logic [DATA_W-1:0]     accWdata, ramRdata;

   assign reqIdx = bus.req_addr[HI_LSB-1:WORD_LSB];
   assign reqErr = (bus.req_addr[WORD_LSB-1:0] != '0) | (|bus.req_addr[ADDR_W-1:HI_LSB]);
   assign accept = bus.req_valid & bus.req_ready;

   always_comb begin
      stateD = stateQ;
      cntD   = cntQ;
      unique case (stateQ)
         IDLE, RESP: begin
            if (accept) begin
               stateD = (LATENCY == 0) ? RESP : WAIT;
               cntD   = LAT;
            end else begin
               stateD = IDLE;
            end
         end
         WAIT: begin
            cntD = cntQ - CNT_W'(1);
            if (cntQ <= CNT_W'(1)) begin
               stateD = RESP;
            end
         end
         default: stateD = IDLE;
      endcase
   end

   assign enterResp = (stateD == RESP);

   // With zero latency the access happens on the accepting edge, before capture.
   assign accWe    = (LATENCY == 0) ? bus.req_we    : capWe;
   assign accErr   = (LATENCY == 0) ? reqErr        : capErr;
   assign accIdx   = (LATENCY == 0) ? reqIdx        : capIdx;
   assign accWdata = (LATENCY == 0) ? bus.req_wdata : capWdata;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stateQ   <= IDLE;
         cntQ     <= '0;
         capWe    <= 1'b0;
         capErr   <= 1'b0;
         capIdx   <= '0;
         capWdata <= '0;
         respErrQ <= 1'b0;
         zeroQ    <= 1'b1;
      end else begin
         stateQ <= stateD;
         cntQ   <= cntD;
         if (accept) begin
            capWe    <= bus.req_we;
            capErr   <= reqErr;
            capIdx   <= reqIdx;
            capWdata <= bus.req_wdata;
         end
         if (enterResp) begin
            respErrQ <= accErr;
            zeroQ    <= accWe | accErr;
         end
      end
   end

   mem_array #(
      .DATA_W    (DATA_W),
      .DEPTH_LOG2(DEPTH_LOG2)
   ) uArray (
      .clk  (clk),
      .en   (enterResp & ~accErr),
      .we   (accWe),
      .addr (accIdx),
      .wdata(accWdata),
      .rdata(ramRdata)
   );

   assign bus.req_ready  = (stateQ == IDLE) || (stateQ == RESP);
   assign bus.resp_valid = (stateQ == RESP);
   assign bus.resp_err   = (stateQ == RESP) & respErrQ;
   // Read data register only moves on reads, so rdata holds outside RESP.
   assign bus.resp_rdata = zeroQ ? '0 : ramRdata;
   assign bus.busy       = (stateQ != IDLE);
   assign bus.state      = stateQ;

endmodule
